// File: rtl/nios_hps_system_button_debounce.sv
// Debounces a bank of bouncing pushbuttons. It produces clean active-high levels,
// one-cycle press/release pulses and a registered any-press flag.
module nios_hps_system_button_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic             any_press
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = 1;
    localparam logic [WIDTH-1:0] IDLE_PIN = {WIDTH{ACTIVE_LOW}};

    logic [WIDTH-1:0]         sync_meta;
    logic [WIDTH-1:0]         sync_out;
    logic [WIDTH-1:0]         sample;
    logic [WIDTH-1:0]         toggle;
    logic [WIDTH-1:0][CW-1:0] cnt;
    logic [WIDTH-1:0][CW-1:0] cnt_next;

    assign sample = ACTIVE_LOW ? ~sync_out : sync_out;

    // Each bit counts how long its sample has disagreed with the accepted level;
    // any agreement restarts the count, so short glitches never toggle the level.
    always_comb begin
        toggle   = '0;
        cnt_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sample[i] != btn_level[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    toggle[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta   <= IDLE_PIN;
            sync_out    <= IDLE_PIN;
            cnt         <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            any_press   <= 1'b0;
        end else begin
            sync_meta   <= btn_raw;
            sync_out    <= sync_meta;
            cnt         <= cnt_next;
            btn_level   <= btn_level ^ toggle;
            btn_press   <= toggle & ~btn_level;
            btn_release <= toggle & btn_level;
            any_press   <= |btn_press;
        end
    end

endmodule

// File: doc/nios_hps_system_button_debounce.md
NIOS_HPS_SYSTEM_BUTTON_DEBOUNCE -- requirements
Module: nios_hps_system_button_debounce

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 4, meaning the number of button inputs, in the range 1..32.
REQ-002 The block SHALL provide parameter DEBOUNCE_CYCLES, default 50000, meaning the number of consecutive stable cycles required to accept a new level (1 ms at 50 MHz), with a minimum of 2.
REQ-003 The block SHALL provide parameter ACTIVE_LOW, default 1, where 1 means a raw pin at 0 is a pressed button.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all state is in this domain.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port btn_raw, input, WIDTH bits: asynchronous, bouncing pushbutton pins.
REQ-007 The block SHALL have port btn_level, output, WIDTH bits: debounced level, active-high = pressed; it feeds the PIO in_port.
REQ-008 The block SHALL have port btn_press, output, WIDTH bits: one-cycle pulse per bit when that bit's btn_level rises.
REQ-009 The block SHALL have port btn_release, output, WIDTH bits: one-cycle pulse per bit when that bit's btn_level falls.
REQ-010 The block SHALL have port any_press, output, 1 bit: the registered OR of btn_press, one cycle after btn_press.

Function
REQ-011 Each btn_raw bit SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-012 The synchronizer output SHALL be inverted when ACTIVE_LOW=1 and passed unchanged when ACTIVE_LOW=0, giving the internal sample s[i] with 1 = pressed.
REQ-013 Each bit SHALL have an independent counter of width ceil(log2(DEBOUNCE_CYCLES)); bits SHALL NOT interact.
REQ-014 Per bit, each cycle: if s[i] equals btn_level[i], the counter SHALL clear to 0.
REQ-015 Per bit, each cycle: if s[i] differs from btn_level[i] and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-016 Per bit, each cycle: if s[i] differs from btn_level[i] and the counter equals DEBOUNCE_CYCLES-1, btn_level[i] SHALL toggle and the counter SHALL clear to 0.
REQ-017 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-018 Latency: a pin level held constant from sampling edge k SHALL appear on btn_level at rising edge k+DEBOUNCE_CYCLES+1, i.e. 2 synchronizer cycles plus DEBOUNCE_CYCLES-1 count cycles.
REQ-019 Glitch rejection: any s[i] excursion shorter than DEBOUNCE_CYCLES cycles SHALL restart the count and SHALL leave btn_level, btn_press and btn_release unchanged.
REQ-020 btn_press[i] SHALL be high for exactly the one cycle in which btn_level[i] has just changed 0->1, registered on the same edge as the toggle.
REQ-021 btn_release[i] SHALL behave like btn_press[i] for a 1->0 change.
REQ-022 btn_press[i] and btn_release[i] SHALL never be high together.
REQ-023 Simultaneous toggles on several bits SHALL produce simultaneous pulses on those bits and a single one-cycle any_press.
REQ-024 A held button SHALL produce exactly one btn_press and no further pulses until it is released and re-debounced.

Reset
REQ-025 While reset_n=0, synchronizer flops SHALL hold the idle pin level: 1 if ACTIVE_LOW=1, else 0.
REQ-026 While reset_n=0, counters, btn_level, btn_press, btn_release and any_press SHALL all be 0.
REQ-027 Assertion of reset_n mid-count or while pressed SHALL immediately force the values of REQ-025/026, aborting any count in progress.
REQ-028 A button held through reset release SHALL be reported as a fresh press after the full REQ-018 latency, and the first cycles after reset SHALL produce no spurious pulse.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4, ACTIVE_LOW=1)
REQ-029 Bench: btn_raw 4'hF -> 4'hE held from edge k -> btn_level=4'h1 and btn_press=4'h1 at edge k+5 only; any_press=1 at edge k+6.
REQ-030 Bench: bit0 low for 3 cycles then high, repeated 10 times -> btn_level stays 0 and no pulses.
REQ-031 Bench: from btn_level=4'h1, btn_raw -> 4'hF held -> btn_release=4'h1 for one cycle at edge k+5 and btn_level=0.
REQ-032 Bench: btn_raw 4'hF -> 4'h0 on one edge -> btn_press=4'hF for one cycle and any_press high exactly one cycle.
REQ-033 Bench: reset_n pulsed low at count 2 while bit0 is pressed -> all outputs 0 during reset; btn_press[0] occurs 5 edges after reset release.
REQ-034 Bench: bit0 held low for 1000 cycles -> exactly one btn_press[0] pulse.
